spring_chain_solver: RTL and testbench

//  N-mass spring/damper chain integrated by explicit Euler in 2.16 signed fixed point, time-multiplexed one mass per cycle.

---
 rtl/spring_chain_solver.sv | 202 ++++++++++++++++++++
 tb/tb_spring_chain_solver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spring_chain_solver.sv
// Spring/damper chain integrated by explicit Euler in 2.16 fixed point, one mass per cycle,
// plotting the selected mass's position as one pixel per step over an Avalon master write.
//   state  | meaning
//   IDLE   | waiting; init_we loads a mass, run starts a step
//   CALC   | one mass per cycle into the shadow arrays
//   COMMIT | shadow -> committed arrays, pixel address latched
//   WRITE  | pixel write held until bus_ack
module spring_chain_solver #(
    parameter int          N_MASS     = 4,
    parameter int          WIDTH      = 18,
    parameter logic [31:0] VIDEO_BASE = 32'h0800_0000,
    parameter int          Y_SHIFT    = 12,
    parameter int          Y_OFFSET   = 32,
    parameter logic [7:0]  COLOR      = 8'hFF,
    localparam int         IDX_W      = (N_MASS > 1) ? $clog2(N_MASS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    run,
    input  logic [3:0]              dt,
    input  logic signed [WIDTH-1:0] k_m,
    input  logic signed [WIDTH-1:0] kmid_m,
    input  logic signed [WIDTH-1:0] d_m,
    input  logic                    init_we,
    input  logic [IDX_W-1:0]        init_idx,
    input  logic signed [WIDTH-1:0] init_pos,
    input  logic signed [WIDTH-1:0] init_vel,
    input  logic [IDX_W-1:0]        plot_sel,
    input  logic                    bus_ack,
    output logic [31:0]             bus_addr,
    output logic                    bus_write,
    output logic [31:0]             bus_write_data,
    output logic [3:0]              bus_byte_enable,
    output logic                    busy,
    output logic signed [WIDTH-1:0] plot_pos,
    output logic [31:0]             step_count
);

    localparam int FRAC = 16;
    localparam int EW   = WIDTH + 3;
    localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_COMMIT, S_WRITE} state_t;

    state_t state, state_nx;
    logic   init_en, start, calc_en, commit_en, write_done;

    logic signed [WIDTH-1:0] pos    [N_MASS];
    logic signed [WIDTH-1:0] vel    [N_MASS];
    logic signed [WIDTH-1:0] pos_sh [N_MASS];
    logic signed [WIDTH-1:0] vel_sh [N_MASS];
    logic [IDX_W-1:0]        idx;
    logic [9:0]              x_coord;

    function automatic logic signed [WIDTH-1:0] smul(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        return p[FRAC+WIDTH-1:FRAC];
    endfunction

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [EW-1:0] a);
        if (a > EW'(W_MAX))
            return W_MAX;
        else if (a < EW'(W_MIN))
            return W_MIN;
        else
            return a[WIDTH-1:0];
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        init_en    = 1'b0;
        start      = 1'b0;
        calc_en    = 1'b0;
        commit_en  = 1'b0;
        write_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (init_we) begin
                    init_en = 1'b1;
                end else if (run) begin
                    start    = 1'b1;
                    state_nx = S_CALC;
                end
            end
            S_CALC: begin
                calc_en = 1'b1;
                if (32'(idx) == 32'(N_MASS - 1))
                    state_nx = S_COMMIT;
            end
            S_COMMIT: begin
                commit_en = 1'b1;
                state_nx  = S_WRITE;
            end
            S_WRITE: begin
                if (bus_ack) begin
                    write_done = 1'b1;
                    state_nx   = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Absent neighbours reuse x_i so their coupling term is exactly zero.
    logic [31:0]             idx_ext;
    logic signed [WIDTH-1:0] x_i, v_i, x_prev, x_next;
    logic signed [WIDTH-1:0] t_k, t_d, t_l, t_r;
    logic signed [EW-1:0]    f_sum, f_sh, v_sum, x_sum;
    logic signed [WIDTH-1:0] pos_nx, vel_nx;

    always_comb begin
        idx_ext = 32'(idx);
        x_i     = pos[idx];
        v_i     = vel[idx];
        x_prev  = (idx_ext != 32'd0) ? pos[idx - 1'b1] : x_i;
        x_next  = (idx_ext < 32'(N_MASS - 1)) ? pos[idx + 1'b1] : x_i;
        t_k     = smul(k_m, x_i);
        t_d     = smul(d_m, v_i);
        t_l     = smul(kmid_m, x_prev - x_i);
        t_r     = smul(kmid_m, x_next - x_i);
        f_sum   = EW'(t_l) + EW'(t_r) - EW'(t_k) - EW'(t_d);
        f_sh    = f_sum >>> dt;
        v_sum   = EW'(v_i) + f_sh;
        x_sum   = EW'(x_i) + (EW'(v_i) >>> dt);
        vel_nx  = sat(v_sum);
        pos_nx  = sat(x_sum);
    end

    logic [IDX_W-1:0]        sel;
    logic signed [WIDTH-1:0] p_new;
    logic signed [31:0]      p_ext, y_raw;
    logic [31:0]             y_cl, addr_nx;

    always_comb begin
        sel   = (32'(plot_sel) < 32'(N_MASS)) ? plot_sel : '0;
        p_new = pos_sh[sel];
        p_ext = 32'(p_new);
        y_raw = (p_ext >>> Y_SHIFT) + Y_OFFSET;
        if (y_raw < 0)
            y_cl = 32'd0;
        else if (y_raw > 479)
            y_cl = 32'd479;
        else
            y_cl = y_raw;
        addr_nx = VIDEO_BASE + 32'(x_coord) + (y_cl << 10);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_MASS; i++) begin
                pos[i]    <= '0;
                vel[i]    <= '0;
                pos_sh[i] <= '0;
                vel_sh[i] <= '0;
            end
            idx        <= '0;
            x_coord    <= '0;
            step_count <= '0;
            bus_addr   <= '0;
            bus_write  <= 1'b0;
        end else begin
            if (init_en && (32'(init_idx) < 32'(N_MASS))) begin
                pos[init_idx] <= init_pos;
                vel[init_idx] <= init_vel;
            end
            if (start)
                idx <= '0;
            if (calc_en) begin
                pos_sh[idx] <= pos_nx;
                vel_sh[idx] <= vel_nx;
                idx         <= idx + 1'b1;
            end
            if (commit_en) begin
                pos       <= pos_sh;
                vel       <= vel_sh;
                bus_addr  <= addr_nx;
                bus_write <= 1'b1;
            end
            if (write_done) begin
                bus_write  <= 1'b0;
                step_count <= step_count + 32'd1;
                x_coord    <= (x_coord == 10'd639) ? 10'd0 : x_coord + 10'd1;
            end
        end
    end

    assign busy            = (state != S_IDLE);
    assign plot_pos        = pos[sel];
    assign bus_write_data  = {24'b0, COLOR};
    assign bus_byte_enable = 4'b0001;

endmodule

// File: tb/tb_spring_chain_solver.sv
// Directed bench for spring_chain_solver: a two-mass chain plus a zero-offset twin for the row clamp.
module tb_spring_chain_solver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  dt = '0;
    logic [17:0] k_m = '0, kmid_m = '0, d_m = '0;
    logic        init_we = 1'b0;
    logic [0:0]  init_idx = '0;
    logic [17:0] init_pos = '0, init_vel = '0;
    logic [0:0]  plot_sel = '0;
    logic        bus_ack;
    logic        ack_auto = 1'b1, ack_man = 1'b0;

    logic [31:0] bus_addr, bus_write_data, step_count;
    logic        bus_write, busy;
    logic [3:0]  bus_byte_enable;
    logic [17:0] plot_pos;

    logic [31:0] z_bus_addr, z_bus_write_data, z_step_count;
    logic        z_bus_write, z_busy;
    logic [3:0]  z_bus_byte_enable;
    logic [17:0] z_plot_pos;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    // Immediate ack answers the write in its first WRITE cycle.
    assign bus_ack = ack_auto ? bus_write : ack_man;

    spring_chain_solver #(.N_MASS(2)) dut (
        .clock(clock), .reset(reset), .run(run), .dt(dt),
        .k_m(k_m), .kmid_m(kmid_m), .d_m(d_m),
        .init_we(init_we), .init_idx(init_idx), .init_pos(init_pos), .init_vel(init_vel),
        .plot_sel(plot_sel), .bus_ack(bus_ack),
        .bus_addr(bus_addr), .bus_write(bus_write), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable), .busy(busy), .plot_pos(plot_pos),
        .step_count(step_count)
    );

    spring_chain_solver #(.N_MASS(2), .Y_OFFSET(0)) dut_z (
        .clock(clock), .reset(reset), .run(run), .dt(dt),
        .k_m(k_m), .kmid_m(kmid_m), .d_m(d_m),
        .init_we(init_we), .init_idx(init_idx), .init_pos(init_pos), .init_vel(init_vel),
        .plot_sel(plot_sel), .bus_ack(bus_ack),
        .bus_addr(z_bus_addr), .bus_write(z_bus_write), .bus_write_data(z_bus_write_data),
        .bus_byte_enable(z_bus_byte_enable), .busy(z_busy), .plot_pos(z_plot_pos),
        .step_count(z_step_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [0:0] i, input logic [17:0] p, input logic [17:0] v);
        init_we  = 1'b1;
        init_idx = i;
        init_pos = p;
        init_vel = v;
        tick();
        init_we  = 1'b0;
    endtask

    task automatic do_step(output int lat, output logic [31:0] addr,
                           output logic [31:0] zaddr, output logic [31:0] data);
        run   = 1'b1;
        tick();
        run   = 1'b0;
        lat   = 0;
        addr  = '0;
        zaddr = '0;
        data  = '0;
        while (busy && lat < 100) begin
            if (bus_write) begin
                addr  = bus_addr;
                zaddr = z_bus_addr;
                data  = bus_write_data;
            end
            lat++;
            tick();
        end
    endtask

    task automatic show(input logic [0:0] s, input string tag, input logic [17:0] exp);
        plot_sel = s;
        #1;
        chk(tag, 32'(plot_pos), 32'(exp));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat, cnt, nw;
        logic [31:0] a, za, d;

        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_write", 32'(bus_write), 32'd0);
        chk("rst_steps", step_count, 32'd0);
        chk("rst_pos", 32'(plot_pos), 32'd0);
        chk("byte_en", 32'(bus_byte_enable), 32'd1);

        // Two-mass impulse: masses at -0.5 and +0.5, at rest.
        load(1'b0, 18'h3_8000, 18'h0);
        run = 1'b1;
        load(1'b1, 18'h0_8000, 18'h0);
        chk("init_beats_run", 32'(busy), 32'd0);
        run = 1'b0;
        show(1'b0, "init_pos0", 18'h3_8000);
        show(1'b1, "init_pos1", 18'h0_8000);

        k_m = 18'h1_0000; kmid_m = 18'h1_0000; d_m = 18'h0_4000; dt = 4'd9;
        plot_sel = 1'b0;
        do_step(lat, a, za, d);
        chk("t1_latency", 32'(lat), 32'd4);
        chk("t1_addr", a, 32'h0800_6000);
        chk("t1_data", d, 32'h0000_00FF);
        chk("t4_clamp_addr", za, 32'h0800_0000);
        chk("t1_steps", step_count, 32'd1);
        show(1'b0, "t1_pos0_hold", 18'h3_8000);
        show(1'b1, "t1_pos1_hold", 18'h0_8000);

        // dt=0 exposes the step-1 velocities as position increments.
        dt = 4'd0;
        plot_sel = 1'b0;
        do_step(lat, a, za, d);
        chk("t1b_addr", a, 32'h0800_6001);
        chk("t4b_clamp_addr", za, 32'h0800_0001);
        show(1'b0, "t1b_pos0", 18'h3_80C0);
        show(1'b1, "t1b_pos1", 18'h0_7F40);
        chk("t1b_steps", step_count, 32'd2);

        // Saturation at both rails.
        k_m = '0; kmid_m = '0; d_m = '0; dt = 4'd0;
        load(1'b0, 18'h1_FFFF, 18'h1_FFFF);
        load(1'b1, 18'h2_0000, 18'h2_0000);
        plot_sel = 1'b0;
        do_step(lat, a, za, d);
        chk("t2_addr", a, 32'h0800_FC02);
        chk("t2_z_addr", za, 32'h0800_7C02);
        show(1'b0, "t2_pos0_sat", 18'h1_FFFF);
        show(1'b1, "t2_pos1_sat", 18'h2_0000);
        chk("t2_steps", step_count, 32'd3);

        // Delayed acknowledge.
        plot_sel = 1'b1;
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        cnt = 0;
        while (!bus_write && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("t5_reach_write", 32'(bus_write), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_write", 32'(bus_write), 32'd1);
            chk("t5_hold_addr", bus_addr, 32'h0800_0003);
            chk("t5_hold_steps", step_count, 32'd3);
            tick();
        end
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        chk("t5_drop_write", 32'(bus_write), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_steps", step_count, 32'd4);
        ack_auto = 1'b1;

        // 641 back-to-back steps walk x across the row and wrap.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        plot_sel = 1'b0;
        run = 1'b1;
        nw = 0;
        cnt = 0;
        while (nw < 641 && cnt < 5000) begin
            if (bus_write) begin
                chk("t3_addr", bus_addr, 32'h0800_8000 + 32'(nw % 640));
                nw++;
                if (nw == 641)
                    run = 1'b0;
            end
            cnt++;
            tick();
        end
        run = 1'b0;
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("t3_writes", 32'(nw), 32'd641);
        chk("t3_steps", step_count, 32'd641);
        chk("t3_idle", 32'(busy), 32'd0);

        // Reset during WRITE.
        load(1'b0, 18'h0_4000, 18'h0);
        show(1'b0, "t6_loaded", 18'h0_4000);
        ack_auto = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        cnt = 0;
        while (!bus_write && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("t6_reach_write", 32'(bus_write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_write", 32'(bus_write), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_steps", step_count, 32'd0);
        chk("t6_rst_pos", 32'(plot_pos), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        ack_auto = 1'b1;
        tick();

        // init_we during CALC must not reach the arrays.
        plot_sel = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        init_we  = 1'b1;
        init_idx = 1'b1;
        init_pos = 18'h0_4000;
        init_vel = 18'h0_1000;
        tick();
        init_we = 1'b0;
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("t6_steps_after", step_count, 32'd1);
        show(1'b1, "t6_calc_init_ignored", 18'h0);
        show(1'b0, "t6_pos0_zero", 18'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
